// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD-over-SPI responder: framer states,
// command token layout and the CRC generator polynomials.
package sd_spi_pkg;
   typedef enum logic [1:0] {
      FR_IDLE = 2'd0,
      FR_ARG  = 2'd1,
      FR_CRC  = 2'd2
   } frame_state_e;

   localparam logic [1:0]  START_BITS    = 2'b01;
   localparam logic [15:0] CRC16_POLY    = 16'h1021;
   localparam logic [6:0]  CRC7_POLY     = 7'h09;
   localparam int          CMD_ARG_BYTES = 4;
endpackage

// File: rtl/sd_crc7_byte.sv
// Combinational CRC7 (x^7+x^3+1) advance over one byte, MSB first.
module sd_crc7_byte
   import sd_spi_pkg::*;
(
   input  logic [6:0] crc_i,
   input  logic [7:0] dat_i,
   output logic [6:0] crc_o
);
   logic [6:0] c;
   logic       fb;

   always_comb begin
      c  = crc_i;
      fb = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         fb = dat_i[i] ^ c[6];
         c  = {c[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'd0);
      end
      crc_o = c;
   end
endmodule

// File: rtl/spi_sd_responder.sv
// SD-over-SPI card-side mode-0 slave: oversampled pins, one-deep tx holding
// register, 6-byte command framer with CRC7 check, and a CRC16 tap.
module spi_sd_responder
   import sd_spi_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] FILL_BYTE   = 8'hFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cs_n,
   input  logic        sclk,
   input  logic        mosi,
   output logic        miso,
   output logic        miso_oe,
   input  logic [7:0]  tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic        tx_underrun,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   output logic        cmd_valid,
   output logic [5:0]  cmd_index,
   output logic [31:0] cmd_arg,
   output logic        cmd_crc_ok,
   input  logic        crc_reset,
   input  logic        crc_source,
   output logic [15:0] crc_out,
   output logic        busy
);
   localparam logic [1:0] ARG_LAST = 2'(CMD_ARG_BYTES - 1);

   logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
   logic                   cs_prev_q, sclk_prev_q;
   logic                   cs_s, sclk_s, mosi_s;
   logic                   cs_fall, sclk_rise, sclk_fall, reload, accept, byte_done;
   logic [7:0]             byte_new;
   logic [2:0]             bit_cnt_q;
   logic [6:0]             rx_shift_q;
   logic [7:0]             tx_shift_q, hold_q, rx_data_q;
   logic                   hold_full_q, oe_q, underrun_q, rx_valid_q;
   logic [15:0]            crc_q;
   logic                   crc_fb;

   frame_state_e state_q, state_d;
   logic [1:0]   arg_cnt_q, arg_cnt_d;
   logic [6:0]   crc7_q, crc7_d, crc7_seed, crc7_next;
   logic [5:0]   cmd_index_q, cmd_index_d;
   logic [31:0]  cmd_arg_q, cmd_arg_d;
   logic         cmd_ok_q, cmd_ok_d, cmd_valid_q, cmd_valid_d;

   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign cs_fall   = cs_prev_q & ~cs_s;
   assign sclk_rise = ~cs_s & sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~cs_s & ~sclk_s & sclk_prev_q;
   assign reload    = cs_fall | (sclk_fall & (bit_cnt_q == 3'd0));
   assign accept    = tx_valid & ~hold_full_q;
   assign byte_done = sclk_rise & (bit_cnt_q == 3'd7);
   assign byte_new  = {rx_shift_q, mosi_s};
   assign crc_fb    = (crc_source ? miso : mosi_s) ^ crc_q[15];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cs_sync_q   <= '1;
         sclk_sync_q <= '0;
         mosi_sync_q <= '1;
         cs_prev_q   <= 1'b1;
         sclk_prev_q <= 1'b0;
         bit_cnt_q   <= 3'd0;
         rx_shift_q  <= 7'd0;
         tx_shift_q  <= 8'hFF;
         hold_q      <= 8'd0;
         hold_full_q <= 1'b0;
         oe_q        <= 1'b0;
         underrun_q  <= 1'b0;
         rx_data_q   <= 8'd0;
         rx_valid_q  <= 1'b0;
         crc_q       <= 16'd0;
      end else begin
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
         cs_prev_q   <= cs_s;
         sclk_prev_q <= sclk_s;
         underrun_q  <= 1'b0;
         rx_valid_q  <= 1'b0;
         // A reload in the same cycle as an accept sees the register as it was.
         hold_full_q <= accept | (hold_full_q & ~reload);
         if (accept) hold_q <= tx_data;
         if (cs_s) begin
            bit_cnt_q <= 3'd0;
            oe_q      <= 1'b0;
         end else begin
            if (cs_fall) oe_q <= 1'b1;
            if (sclk_rise) begin
               rx_shift_q <= byte_new[6:0];
               bit_cnt_q  <= bit_cnt_q + 3'd1;
            end
            if (byte_done) begin
               rx_data_q  <= byte_new;
               rx_valid_q <= 1'b1;
            end
            if (reload) begin
               tx_shift_q <= hold_full_q ? hold_q : FILL_BYTE;
               underrun_q <= ~hold_full_q;
            end else if (sclk_fall) begin
               tx_shift_q <= {tx_shift_q[6:0], 1'b1};
            end
         end
         if (sclk_rise)      crc_q <= {crc_q[14:0], 1'b0} ^ (crc_fb ? CRC16_POLY : 16'd0);
         else if (crc_reset) crc_q <= 16'd0;
      end
   end

   assign crc7_seed = (state_q == FR_IDLE) ? 7'd0 : crc7_q;

   sd_crc7_byte u_crc7 (
      .crc_i (crc7_seed),
      .dat_i (byte_new),
      .crc_o (crc7_next)
   );

   always_comb begin
      state_d     = state_q;
      arg_cnt_d   = arg_cnt_q;
      crc7_d      = crc7_q;
      cmd_index_d = cmd_index_q;
      cmd_arg_d   = cmd_arg_q;
      cmd_ok_d    = cmd_ok_q;
      cmd_valid_d = 1'b0;
      if (cs_s) begin
         state_d = FR_IDLE;
      end else if (byte_done) begin
         case (state_q)
            FR_IDLE: if (byte_new[7:6] == START_BITS) begin
               cmd_index_d = byte_new[5:0];
               crc7_d      = crc7_next;
               arg_cnt_d   = 2'd0;
               state_d     = FR_ARG;
            end
            FR_ARG: begin
               cmd_arg_d = {cmd_arg_q[23:0], byte_new};
               crc7_d    = crc7_next;
               arg_cnt_d = arg_cnt_q + 2'd1;
               if (arg_cnt_q == ARG_LAST) state_d = FR_CRC;
            end
            FR_CRC: begin
               cmd_ok_d    = (byte_new[7:1] == crc7_q) & byte_new[0];
               cmd_valid_d = 1'b1;
               state_d     = FR_IDLE;
            end
            default: state_d = FR_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= FR_IDLE;
         arg_cnt_q   <= 2'd0;
         crc7_q      <= 7'd0;
         cmd_index_q <= 6'd0;
         cmd_arg_q   <= 32'd0;
         cmd_ok_q    <= 1'b0;
         cmd_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         arg_cnt_q   <= arg_cnt_d;
         crc7_q      <= crc7_d;
         cmd_index_q <= cmd_index_d;
         cmd_arg_q   <= cmd_arg_d;
         cmd_ok_q    <= cmd_ok_d;
         cmd_valid_q <= cmd_valid_d;
      end
   end

   assign miso        = oe_q ? tx_shift_q[7] : 1'b1;
   assign miso_oe     = oe_q;
   assign tx_ready    = ~hold_full_q;
   assign tx_underrun = underrun_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign cmd_valid   = cmd_valid_q;
   assign cmd_index   = cmd_index_q;
   assign cmd_arg     = cmd_arg_q;
   assign cmd_crc_ok  = cmd_ok_q;
   assign crc_out     = crc_q;
   assign busy        = (bit_cnt_q != 3'd0);
endmodule

// File: tb/tb_spi_sd_responder.sv
// Directed + randomized bench for spi_sd_responder with a polynomial-division
// reference for CRC7/CRC16 and pulse counters sampled on the falling clk edge.
module tb_spi_sd_responder;
   logic        clk = 1'b0;
   logic        rst, cs_n, sclk, mosi, tx_valid, crc_reset, crc_source;
   logic [7:0]  tx_data;
   logic        miso, miso_oe, tx_ready, tx_underrun, rx_valid, cmd_valid, cmd_crc_ok, busy;
   logic [7:0]  rx_data;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_arg;
   logic [15:0] crc_out;

   int n_cmp = 0;
   int n_bad = 0;
   int rxv_cnt = 0;
   int und_cnt = 0;
   int cmdv_cnt = 0;
   logic [5:0]  cap_idx = 6'd0;
   logic [31:0] cap_arg = 32'd0;
   logic        cap_ok = 1'b0;

   always #5 clk = ~clk;

   spi_sd_responder dut (
      .clk(clk), .rst(rst), .cs_n(cs_n), .sclk(sclk), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_underrun(tx_underrun),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .cmd_valid(cmd_valid), .cmd_index(cmd_index), .cmd_arg(cmd_arg), .cmd_crc_ok(cmd_crc_ok),
      .crc_reset(crc_reset), .crc_source(crc_source), .crc_out(crc_out), .busy(busy)
   );

   always @(negedge clk) begin
      if (rx_valid) rxv_cnt++;
      if (tx_underrun) und_cnt++;
      if (cmd_valid) begin
         cmdv_cnt++;
         cap_idx = cmd_index;
         cap_arg = cmd_arg;
         cap_ok  = cmd_crc_ok;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Remainder of M(x)*x^7 divided by x^7+x^3+1.
   function automatic logic [6:0] crc7_ref(input logic [39:0] m);
      logic [46:0] r;
      r = {m, 7'd0};
      for (int i = 46; i >= 7; i--)
         if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
      return r[6:0];
   endfunction

   function automatic logic [15:0] crc16_ref(input logic [71:0] m);
      logic [87:0] r;
      r = {m, 16'd0};
      for (int i = 87; i >= 16; i--)
         if (r[i]) r[i -: 17] = r[i -: 17] ^ 17'h11021;
      return r[15:0];
   endfunction

   // Host side of one transfer, sclk = clk/8; optionally offers a tx byte
   // timed to land on the same clk as the responder's byte-boundary reload.
   task automatic spi_xfer(input logic [7:0] mo, input int nbits, input bit acc,
                           input logic [7:0] accd, output logic [7:0] mi);
      mi = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         mosi = mo[i];
         repeat (4) @(negedge clk);
         mi[i] = miso;
         sclk = 1'b1;
         repeat (4) @(negedge clk);
         sclk = 1'b0;
      end
      if (acc) begin
         repeat (2) @(negedge clk);
         tx_data  = accd;
         tx_valid = 1'b1;
         @(negedge clk);
         tx_valid = 1'b0;
         repeat (2) @(negedge clk);
      end else begin
         repeat (4) @(negedge clk);
      end
   endtask

   task automatic cs_low();
      cs_n = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic cs_high();
      cs_n = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic push_tx(input logic [7:0] d);
      check("tx_ready_before_push", 64'(tx_ready), 64'(1));
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic pulse_crc_reset();
      crc_reset = 1'b1;
      @(negedge clk);
      crc_reset = 1'b0;
      @(negedge clk);
      check("crc_after_reset", 64'(crc_out), 64'(0));
   endtask

   task automatic check_rst(input string p);
      check({p, "_miso"}, 64'(miso), 64'(1));
      check({p, "_miso_oe"}, 64'(miso_oe), 64'(0));
      check({p, "_tx_ready"}, 64'(tx_ready), 64'(1));
      check({p, "_pulses"}, 64'({tx_underrun, rx_valid, cmd_valid}), 64'(0));
      check({p, "_rx_data"}, 64'(rx_data), 64'(0));
      check({p, "_cmd_index"}, 64'(cmd_index), 64'(0));
      check({p, "_cmd_arg"}, 64'(cmd_arg), 64'(0));
      check({p, "_cmd_crc_ok"}, 64'(cmd_crc_ok), 64'(0));
      check({p, "_crc_out"}, 64'(crc_out), 64'(0));
      check({p, "_busy"}, 64'(busy), 64'(0));
   endtask

   task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] last,
                          input bit with_lead, input logic [7:0] lead);
      logic [47:0] f;
      logic [7:0]  rd;
      logic        exp_ok;
      int          c0, r0;
      exp_ok = (last[7:1] == crc7_ref({2'b01, idx, arg})) && last[0];
      f  = {2'b01, idx, arg, last};
      c0 = cmdv_cnt;
      r0 = rxv_cnt;
      cs_low();
      if (with_lead) spi_xfer(lead, 8, 1'b0, 8'h00, rd);
      for (int b = 5; b >= 0; b--) begin
         spi_xfer(f[8*b +: 8], 8, 1'b0, 8'h00, rd);
         check("rx_data", 64'(rx_data), 64'(f[8*b +: 8]));
      end
      cs_high();
      check("cmd_valid_count", 64'(cmdv_cnt - c0), 64'(1));
      check("rx_valid_count", 64'(rxv_cnt - r0), with_lead ? 64'(7) : 64'(6));
      check("cmd_index", 64'(cap_idx), 64'(idx));
      check("cmd_arg", 64'(cap_arg), 64'(arg));
      check("cmd_crc_ok", 64'(cap_ok), 64'(exp_ok));
   endtask

   initial begin
      logic [7:0]  rd, x, lead, last;
      logic [5:0]  idx;
      logic [31:0] arg;
      logic [71:0] msg;
      int          u0, r0, c0, sel;

      rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b1;
      tx_valid = 1'b0; tx_data = 8'h00; crc_reset = 1'b0; crc_source = 1'b0;
      repeat (3) @(negedge clk);
      check_rst("reset");
      rst = 1'b0;
      repeat (4) @(negedge clk);

      run_cmd(6'd0, 32'd0, 8'h95, 1'b0, 8'h00);
      run_cmd(6'd8, 32'h000001AA, 8'h87, 1'b0, 8'h00);
      run_cmd(6'd8, 32'h000001AA, 8'h86, 1'b0, 8'h00);
      run_cmd(6'd8, 32'h000001AA, 8'h89, 1'b0, 8'h00);

      for (int k = 0; k < 6; k++) begin
         idx  = 6'($urandom_range(0, 63));
         arg  = $urandom;
         sel  = int'($urandom_range(0, 2));
         last = {crc7_ref({2'b01, idx, arg}), 1'b1};
         if (sel == 1) last[0] = 1'b0;
         else if (sel == 2) last[7] = ~last[7];
         lead = 8'($urandom);
         if (lead[7:6] == 2'b01) lead[7] = 1'b1;
         run_cmd(idx, arg, last, (k % 2) == 1, lead);
      end

      // Preloaded byte, then an empty register at the next boundary.
      push_tx(8'h01);
      check("tx_ready_held", 64'(tx_ready), 64'(0));
      u0 = und_cnt;
      cs_low();
      check("underrun_at_cs_fall", 64'(und_cnt - u0), 64'(0));
      check("tx_ready_after_load", 64'(tx_ready), 64'(1));
      check("miso_oe_active", 64'(miso_oe), 64'(1));
      spi_xfer(8'hFF, 8, 1'b0, 8'h00, rd);
      check("tx_byte0", 64'(rd), 64'(8'h01));
      check("underrun_at_boundary", 64'(und_cnt - u0), 64'(1));
      spi_xfer(8'hFF, 8, 1'b0, 8'h00, rd);
      check("tx_byte1", 64'(rd), 64'(8'hFF));
      cs_high();

      // Accept coinciding with the reload of an empty register.
      x = 8'($urandom_range(0, 254));
      cs_low();
      u0 = und_cnt;
      spi_xfer(8'hFF, 8, 1'b1, x, rd);
      check("sim_byte0", 64'(rd), 64'(8'hFF));
      check("sim_underrun", 64'(und_cnt - u0), 64'(1));
      check("sim_tx_ready", 64'(tx_ready), 64'(0));
      spi_xfer(8'hFF, 8, 1'b0, 8'h00, rd);
      check("sim_byte1", 64'(rd), 64'(8'hFF));
      spi_xfer(8'hFF, 8, 1'b0, 8'h00, rd);
      check("sim_byte2", 64'(rd), 64'(x));
      cs_high();

      msg = "123456789";
      crc_source = 1'b0;
      pulse_crc_reset();
      cs_low();
      for (int i = 0; i < 9; i++) spi_xfer(msg[8*(8-i) +: 8], 8, 1'b0, 8'h00, rd);
      cs_high();
      check("crc16_mosi", 64'(crc_out), 64'(crc16_ref(msg)));
      check("crc16_mosi_hold", 64'(crc_out), 64'(16'h31C3));

      crc_source = 1'b1;
      pulse_crc_reset();
      push_tx(msg[71:64]);
      cs_low();
      for (int i = 0; i < 9; i++) begin
         if (i < 8) push_tx(msg[8*(7-i) +: 8]);
         spi_xfer(8'hFF, 8, 1'b0, 8'h00, rd);
         check("miso_stream", 64'(rd), 64'(msg[8*(8-i) +: 8]));
      end
      cs_high();
      check("crc16_miso", 64'(crc_out), 64'(crc16_ref(msg)));
      crc_source = 1'b0;

      // Abort: three command bytes and half a byte, then deselect.
      c0 = cmdv_cnt;
      r0 = rxv_cnt;
      cs_low();
      spi_xfer(8'h48, 8, 1'b0, 8'h00, rd);
      spi_xfer(8'h00, 8, 1'b0, 8'h00, rd);
      spi_xfer(8'h00, 8, 1'b0, 8'h00, rd);
      spi_xfer(8'h00, 4, 1'b0, 8'h00, rd);
      check("abort_busy_mid", 64'(busy), 64'(1));
      cs_high();
      check("abort_cmd_count", 64'(cmdv_cnt - c0), 64'(0));
      check("abort_rx_count", 64'(rxv_cnt - r0), 64'(3));
      check("abort_miso_oe", 64'(miso_oe), 64'(0));
      check("abort_miso", 64'(miso), 64'(1));
      check("abort_busy", 64'(busy), 64'(0));
      run_cmd(6'd0, 32'd0, 8'h95, 1'b0, 8'h00);

      // Reset in the middle of a byte with non-reset state everywhere.
      run_cmd(6'd8, 32'h000001AA, 8'h87, 1'b0, 8'h00);
      cs_low();
      push_tx(8'h5A);
      spi_xfer(8'hA5, 3, 1'b0, 8'h00, rd);
      check("pre_reset_busy", 64'(busy), 64'(1));
      #2;
      rst = 1'b1;
      #1;
      check_rst("midreset");
      @(negedge clk);
      cs_n = 1'b1;
      rst  = 1'b0;
      repeat (6) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
